// File: rtl/count_decoder.sv
// Binary/Gray 3-bit counter decoder with a +1 sequence tracker (UNLOCK -> ACQ -> LOCKED).
// Optional saturating error counter on the err_cnt port, enabled by COUNT_DECODER_ERRCNT_EN.
module count_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode,
  input  logic       in_valid,
  input  logic [2:0] count_in,
  output logic [2:0] bin_out,
  output logic       out_valid,
  output logic       locked,
  output logic       seq_err
`ifdef COUNT_DECODER_ERRCNT_EN
  ,
  output logic [3:0] err_cnt
`endif
);

  typedef enum logic [1:0] {
    StUnlock,
    StAcq,
    StLocked
  } state_e;

  state_e     state_q, state_d;
  logic       m_q, m_d;
  logic [2:0] ref_q, ref_d;
  logic       mode_q, mode_d;
  logic [2:0] bin_q, bin_d;
  logic       out_valid_q, out_valid_d;
  logic       seq_err_q, seq_err_d;

  logic [2:0] dec;
  logic [2:0] expected;
  logic       match;

  always_comb begin
    if (mode) begin
      dec[2] = count_in[2];
      dec[1] = count_in[2] ^ count_in[1];
      dec[0] = count_in[2] ^ count_in[1] ^ count_in[0];
    end else begin
      dec = count_in;
    end
  end

  // 3-bit add wraps 7 -> 0; a repeated value never equals ref+1, so it counts as a mismatch.
  assign expected = ref_q + 3'd1;
  assign match    = (dec == expected);

  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    ref_d       = ref_q;
    mode_d      = mode_q;
    bin_d       = bin_q;
    out_valid_d = 1'b0;
    seq_err_d   = 1'b0;
    if (in_valid) begin
      bin_d       = dec;
      out_valid_d = 1'b1;
      ref_d       = dec;
      mode_d      = mode;
      // A code change restarts acquisition silently, whatever the current state.
      if ((mode != mode_q) || (state_q == StUnlock)) begin
        state_d = StAcq;
        m_d     = 1'b0;
      end else begin
        unique case (state_q)
          StAcq: begin
            if (match) begin
              if (m_q) begin
                state_d = StLocked;
                m_d     = 1'b0;
              end else begin
                m_d = 1'b1;
              end
            end else begin
              m_d = 1'b0;
            end
          end
          StLocked: begin
            if (!match) begin
              seq_err_d = 1'b1;
              m_d       = 1'b0;
              state_d   = StAcq;
            end
          end
          default: begin
            state_d = StUnlock;
            m_d     = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StUnlock;
      m_q         <= 1'b0;
      ref_q       <= 3'd0;
      mode_q      <= 1'b0;
      bin_q       <= 3'd0;
      out_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      ref_q       <= ref_d;
      mode_q      <= mode_d;
      bin_q       <= bin_d;
      out_valid_q <= out_valid_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign bin_out   = bin_q;
  assign out_valid = out_valid_q;
  assign locked    = (state_q == StLocked);
  assign seq_err   = seq_err_q;

`ifdef COUNT_DECODER_ERRCNT_EN
  logic [3:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (seq_err_d && (err_cnt_q != 4'd15)) begin
      err_cnt_d = err_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_cnt_q <= 4'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
